// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg -- shared definitions for the pipelined carry-lookahead adder.
//   WIDTH_DEF / GROUP_DEF : default operand width and lookahead group width
//   op_e                  : operation selector (add / subtract)
//   stage_ctrl_t          : control half of the stage-1 pipeline register
// ---------------------------------------------------------------------------
package cla_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int GROUP_DEF = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Everything stage 1 hands to stage 2 besides the data halves.
  typedef struct packed {
    logic valid;  // stage holds a live operation
    op_e  op;     // operation, needed to re-invert the high B half
    logic carry;  // carry out of the low half
  } stage_ctrl_t;

endpackage

// File: rtl/cla_group.sv
// ---------------------------------------------------------------------------
// cla_group -- GROUP-bit combinational adder slice for a two-level CLA.
//   a, b : GROUP-bit operands
//   cin  : carry into the group
//   s    : GROUP-bit sum
//   p, g : group propagate / generate (independent of cin)
// ---------------------------------------------------------------------------
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = GROUP_DEF
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             p,
  output logic             g
);

  logic [GROUP-1:0] gen;
  logic [GROUP-1:0] prop;
  logic [GROUP:0]   c;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Sum path: the only part that depends on cin.
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = gen[i] | (prop[i] & c[i]);
    end
    s = prop ^ c[GROUP-1:0];
  end

  // Group P/G kept in a separate block so the second-level carry unit,
  // which feeds cin back in, sees no false combinational loop.
  always_comb begin
    p = &prop;
    g = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      g = gen[i] | (prop[i] & g);
    end
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder -- two-stage pipelined carry-lookahead adder/subtractor
// with valid/ready handshaking on both sides.
//   Clk, Reset          : clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake; transfer when both are 1
//   A, B, cin, sub      : operands; sub=1 computes A + ~B + 1 (cin ignored)
//   out_valid/out_ready : output handshake; result held until taken
//   S, cout             : sum and carry out (for subtract, cout=1 = no borrow)
//   ovf, N, Z, P        : status flags; built only when ADDER_FLAGS_EN is
//                         defined, otherwise tied to 0
// Stage 1 adds the low half, stage 2 adds the high half with the registered
// low-half carry. Each half is GROUP-bit groups plus a group carry unit.
// ---------------------------------------------------------------------------
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int GROUP = GROUP_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             N,
  output logic             Z,
  output logic             P
);

  localparam int HALF = WIDTH / 2;
  localparam int NG   = HALF / GROUP;

  // Pipeline state
  stage_ctrl_t      s1_ctrl_q, s1_ctrl_d;
  logic [HALF-1:0]  s1_lo_q, s1_lo_d;
  logic [HALF-1:0]  s1_a_hi_q, s1_a_hi_d;
  logic [HALF-1:0]  s1_b_hi_q, s1_b_hi_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;

  // Datapath
  logic             c0;
  logic [HALF-1:0]  b_lo_eff, b_hi_eff;
  logic [HALF-1:0]  lo_sum, hi_sum;
  logic [NG-1:0]    lo_p, lo_g, hi_p, hi_g;
  logic [NG:0]      lo_c, hi_c;
  logic             s1_adv, push, load_s2;

  // Subtract is A + ~B + 1: invert B and force the carry-in.
  assign c0       = sub ? 1'b1 : cin;
  assign b_lo_eff = sub ? ~B[HALF-1:0] : B[HALF-1:0];
  assign b_hi_eff = (s1_ctrl_q.op == OP_SUB) ? ~s1_b_hi_q : s1_b_hi_q;

  // Second-level carry units, one per half.
  always_comb begin
    lo_c    = '0;
    lo_c[0] = c0;
    for (int k = 0; k < NG; k++) begin
      lo_c[k+1] = lo_g[k] | (lo_p[k] & lo_c[k]);
    end
  end

  always_comb begin
    hi_c    = '0;
    hi_c[0] = s1_ctrl_q.carry;
    for (int k = 0; k < NG; k++) begin
      hi_c[k+1] = hi_g[k] | (hi_p[k] & hi_c[k]);
    end
  end

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_lo (
      .a   (A[gi*GROUP +: GROUP]),
      .b   (b_lo_eff[gi*GROUP +: GROUP]),
      .cin (lo_c[gi]),
      .s   (lo_sum[gi*GROUP +: GROUP]),
      .p   (lo_p[gi]),
      .g   (lo_g[gi])
    );
    cla_group #(.GROUP(GROUP)) u_hi (
      .a   (s1_a_hi_q[gi*GROUP +: GROUP]),
      .b   (b_hi_eff[gi*GROUP +: GROUP]),
      .cin (hi_c[gi]),
      .s   (hi_sum[gi*GROUP +: GROUP]),
      .p   (hi_p[gi]),
      .g   (hi_g[gi])
    );
  end

  // Handshake and next-state
  always_comb begin
    s1_adv   = !s2_valid_q || out_ready;
    in_ready = !s1_ctrl_q.valid || s1_adv;
    push     = in_valid && in_ready;
    load_s2  = s1_adv && s1_ctrl_q.valid;

    s1_ctrl_d  = s1_ctrl_q;
    s1_lo_d    = s1_lo_q;
    s1_a_hi_d  = s1_a_hi_q;
    s1_b_hi_d  = s1_b_hi_q;
    s2_valid_d = s2_valid_q;
    s_d        = s_q;
    cout_d     = cout_q;

    if (push) begin
      s1_ctrl_d.valid = 1'b1;
      s1_ctrl_d.op    = sub ? OP_SUB : OP_ADD;
      s1_ctrl_d.carry = lo_c[NG];
      s1_lo_d         = lo_sum;
      s1_a_hi_d       = A[WIDTH-1:HALF];
      s1_b_hi_d       = B[WIDTH-1:HALF];
    end else if (s1_adv) begin
      s1_ctrl_d.valid = 1'b0;
    end

    if (s1_adv) begin
      s2_valid_d = s1_ctrl_q.valid;
    end
    // Result registers only change when a live operation arrives, so they
    // hold their last value while the pipeline is empty.
    if (load_s2) begin
      s_d    = {hi_sum, s1_lo_q};
      cout_d = hi_c[NG];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_ctrl_q  <= '0;
      s1_lo_q    <= '0;
      s1_a_hi_q  <= '0;
      s1_b_hi_q  <= '0;
      s2_valid_q <= 1'b0;
      s_q        <= '0;
      cout_q     <= 1'b0;
    end else begin
      s1_ctrl_q  <= s1_ctrl_d;
      s1_lo_q    <= s1_lo_d;
      s1_a_hi_q  <= s1_a_hi_d;
      s1_b_hi_q  <= s1_b_hi_d;
      s2_valid_q <= s2_valid_d;
      s_q        <= s_d;
      cout_q     <= cout_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign S         = s_q;
  assign cout      = cout_q;

`ifdef ADDER_FLAGS_EN
  logic ovf_q, ovf_d, n_q, n_d, z_q, z_d, p_q, p_d;

  // Signed overflow: operands agree in sign but the sum does not.
  always_comb begin
    ovf_d = ovf_q;
    n_d   = n_q;
    z_d   = z_q;
    p_d   = p_q;
    if (load_s2) begin
      ovf_d = (s1_a_hi_q[HALF-1] == b_hi_eff[HALF-1]) &&
              (hi_sum[HALF-1] != s1_a_hi_q[HALF-1]);
      n_d   = hi_sum[HALF-1];
      z_d   = ({hi_sum, s1_lo_q} == '0);
      p_d   = !n_d && !z_d;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ovf_q <= 1'b0;
      n_q   <= 1'b0;
      z_q   <= 1'b0;
      p_q   <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      n_q   <= n_d;
      z_q   <= z_d;
      p_q   <= p_d;
    end
  end

  assign ovf = ovf_q;
  assign N   = n_q;
  assign Z   = z_q;
  assign P   = p_q;
`else
  assign ovf = 1'b0;
  assign N   = 1'b0;
  assign Z   = 1'b0;
  assign P   = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_pipe_adder -- self-checking bench for cla_pipe_adder (16-bit default
// instance plus a 32-bit instance). Flag expectations collapse to 0 unless
// ADDER_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
module tb_cla_pipe_adder;

`ifdef ADDER_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic        Clk, Reset;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic        ovf, N, Z, P;
  logic [15:0] A, B, S;

  logic        in_valid_w, in_ready_w, cin_w, sub_w, out_valid_w, out_ready_w, cout_w;
  logic        ovf_w, n_w, z_w, p_w;
  logic [31:0] a_w, b_w, s_w;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [16:0] exp_q[$];  // {cout, S}

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] s;
    logic        cout;
    logic [3:0]  flags;  // {ovf, N, Z, P}
  } vec_t;

  vec_t vecs[12];

  cla_pipe_adder dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .S(S), .cout(cout), .ovf(ovf), .N(N), .Z(Z), .P(P)
  );

  cla_pipe_adder #(.WIDTH(32), .GROUP(4)) dut_w (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .A(a_w), .B(b_w), .cin(cin_w), .sub(sub_w), .out_valid(out_valid_w),
    .out_ready(out_ready_w), .S(s_w), .cout(cout_w), .ovf(ovf_w), .N(n_w),
    .Z(z_w), .P(p_w)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s, input logic c);
    if (s) return {1'b0, a} + {1'b0, ~b} + 17'd1;
    return {1'b0, a} + {1'b0, b} + {16'd0, c};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  // One clock with scoreboard: inputs were set at edge+1 by the caller.
  task automatic step(output bit pushed, output bit popped);
    logic [16:0] e;
    #2;
    pushed = in_valid && in_ready;
    popped = out_valid && out_ready;
    if (popped) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("seq_result", {15'd0, cout, S}, {15'd0, e});
        $display("cycle %0d: result S=0x%04h cout=%b", cyc, S, cout);
      end
    end else if (out_valid && exp_q.size() > 0) begin
      check("hold_S", {15'd0, cout, S}, {15'd0, exp_q[0]});
    end
    if (pushed) exp_q.push_back(model(A, B, sub, cin));
    tick();
  endtask

  initial begin
    bit pushed, popped;
    int k, n_pop, first_pop, last_pop, push_done, start;

    vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 4'b0001};
    vecs[1]  = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 4'b0100};
    vecs[2]  = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b0, 4'b1100};
    vecs[3]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 4'b0010};
    vecs[4]  = '{16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 4'b0001};
    vecs[5]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 4'b1100};
    vecs[6]  = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 4'b0010};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 4'b1010};
    vecs[8]  = '{16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 16'h0000, 1'b1, 4'b0010};
    vecs[9]  = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 4'b0100};
    vecs[10] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 4'b0001};
    vecs[11] = '{16'h1234, 16'h0000, 1'b0, 1'b1, 16'h1235, 1'b0, 4'b0001};

    Reset = 1'b1;
    in_valid = 1'b0; A = '0; B = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid_w = 1'b0; a_w = '0; b_w = '0; cin_w = 1'b0; sub_w = 1'b0; out_ready_w = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_S", {16'd0, S}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_flags", {28'd0, ovf, N, Z, P}, 32'd0);
    Reset = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // 32-bit instance: carry across every group and the half boundary
    a_w = 32'hFFFF_FFFF; b_w = 32'h0; cin_w = 1'b1; sub_w = 1'b0; in_valid_w = 1'b1;
    #1;
    check("w_in_ready", {31'd0, in_ready_w}, 32'd1);
    tick();
    in_valid_w = 1'b0;
    check("w_lat1_valid", {31'd0, out_valid_w}, 32'd0);
    tick();
    check("w_out_valid", {31'd0, out_valid_w}, 32'd1);
    check("w_S", s_w, 32'h0);
    check("w_cout", {31'd0, cout_w}, 32'd1);
    check("w_flags", {28'd0, ovf_w, n_w, z_w, p_w}, FLAGS_ON ? 32'b0010 : 32'd0);
    $display("wide: A=0xFFFFFFFF B=0 cin=1 -> S=0x%08h cout=%b", s_w, cout_w);
    a_w = 32'h1; b_w = 32'h2; sub_w = 1'b1; cin_w = 1'b0; in_valid_w = 1'b1;
    tick();
    in_valid_w = 1'b0;
    tick();
    check("w_sub_S", s_w, 32'hFFFF_FFFF);
    check("w_sub_cout", {31'd0, cout_w}, 32'd0);
    check("w_sub_flags", {28'd0, ovf_w, n_w, z_w, p_w}, FLAGS_ON ? 32'b0100 : 32'd0);
    $display("wide: A=0x1 - B=0x2 -> S=0x%08h cout=%b", s_w, cout_w);
    tick();

    // Table-driven single operations with exact latency
    for (int i = 0; i < 12; i++) begin
      A = vecs[i].a; B = vecs[i].b; sub = vecs[i].sub; cin = vecs[i].cin;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check("vec_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      check("vec_lat1_valid", {31'd0, out_valid}, 32'd0);
      tick();
      check("vec_out_valid", {31'd0, out_valid}, 32'd1);
      check("vec_S", {16'd0, S}, {16'd0, vecs[i].s});
      check("vec_cout", {31'd0, cout}, {31'd0, vecs[i].cout});
      check("vec_flags", {28'd0, ovf, N, Z, P}, FLAGS_ON ? {28'd0, vecs[i].flags} : 32'd0);
      $display("vec %0d: A=0x%04h B=0x%04h sub=%b cin=%b -> S=0x%04h cout=%b flags=%b%b%b%b",
               i, A, B, sub, cin, S, cout, ovf, N, Z, P);
      tick();
      check("vec_drained", {31'd0, out_valid}, 32'd0);
    end

    // 8 back-to-back transfers, out_ready held high
    k = 0; n_pop = 0; first_pop = -1; last_pop = -1; push_done = -1;
    start = cyc;
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      in_valid = (k < 8);
      A = 16'h0101 * 16'(k + 1); B = 16'h0F0F ^ 16'(k); sub = k[0]; cin = k[1];
      if (k == 8 && exp_q.size() == 0) break;
      step(pushed, popped);
      if (pushed) begin
        k++;
        if (k == 8) push_done = cyc - start;
      end
      if (popped) begin
        n_pop++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
    in_valid = 1'b0;
    check("b2b_push_cycles", push_done, 32'd8);
    check("b2b_result_count", n_pop, 32'd8);
    check("b2b_consecutive", last_pop - first_pop, 32'd7);
    check("b2b_latency", first_pop - start, 32'd3);
    check("b2b_queue_empty", exp_q.size(), 32'd0);

    // Stall: out_ready low for 5 cycles with in_valid high
    k = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      A = 16'h1000 + 16'(k); B = 16'h0200 + 16'(k); sub = 1'b0; cin = 1'b0;
      step(pushed, popped);
      if (pushed) k++;
    end
    #1;
    check("stall_pushes", k, 32'd2);
    check("stall_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("stall_held_S", {16'd0, S}, 32'h1200);
    in_valid = 1'b0; out_ready = 1'b1;
    n_pop = 0;
    for (int c = 0; c < 6; c++) begin
      step(pushed, popped);
      if (popped) n_pop++;
    end
    check("stall_release_count", n_pop, 32'd2);
    check("stall_queue_empty", exp_q.size(), 32'd0);

    // Reset with both stages full
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; A = 16'h3000 + 16'(c); B = 16'h0003; sub = 1'b0; cin = 1'b0;
      step(pushed, popped);
    end
    in_valid = 1'b0;
    #1;
    check("full_out_valid", {31'd0, out_valid}, 32'd1);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    Reset = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_S", {16'd0, S}, 32'd0);
    tick();
    Reset = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) step(pushed, popped);
    check("midrst_no_stale", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
